// File: rtl/kronos_ex_arb.sv
// kronos_ex_arb -- shares one kronos_EX unit between two requesters.
//
// Requester 0 (ID stage) and requester 1 (auxiliary unit) compete for the EX
// input. Every accepted operation pushes its owner ID into a small tag FIFO.
// The FIFO head decides which requester the next EX result is routed to. No
// data path is registered: decode and result pass straight through.
//
// Ports:
//   clk, rst                      clock, async active-high reset
//   req0_decode/req0_vld/req0_rdy requester 0 operation handshake
//   req1_decode/req1_vld/req1_rdy requester 1 operation handshake
//   ex_decode/ex_in_vld/ex_in_rdy operation handshake towards kronos_EX
//   ex_execute/ex_out_vld/ex_out_rdy result handshake from kronos_EX
//   rsp_execute                   result bus shared by both requesters
//   rsp0_vld/rsp0_rdy             requester 0 response handshake
//   rsp1_vld/rsp1_rdy             requester 1 response handshake
//
// Parameter FIFO_DEPTH (1 or 2): number of in-flight operations tracked.
// Macro KRONOS_EX_ARB_RR_EN: round-robin arbitration when defined, otherwise
// requester 0 has fixed priority.

package kronos_ex_arb_pkg;
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_XOR = 3'd2;
  localparam logic [2:0] ALU_AND = 3'd3;
  localparam logic [2:0] ALU_OR  = 3'd4;

  typedef struct packed {
    logic [2:0]  alu_op;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd;
  } pipeIDEX_t;

  typedef struct packed {
    logic [31:0] result1;
    logic [4:0]  rd;
  } pipeEXWB_t;
endpackage

module kronos_ex_arb
  import kronos_ex_arb_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  pipeIDEX_t req0_decode,
  input  logic      req0_vld,
  output logic      req0_rdy,
  input  pipeIDEX_t req1_decode,
  input  logic      req1_vld,
  output logic      req1_rdy,
  output pipeIDEX_t ex_decode,
  output logic      ex_in_vld,
  input  logic      ex_in_rdy,
  input  pipeEXWB_t ex_execute,
  input  logic      ex_out_vld,
  output logic      ex_out_rdy,
  output pipeEXWB_t rsp_execute,
  output logic      rsp0_vld,
  input  logic      rsp0_rdy,
  output logic      rsp1_vld,
  input  logic      rsp1_rdy
);

  localparam logic [1:0] DEPTH_C = 2'(FIFO_DEPTH);

  logic [1:0] count_q;
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] tag_q;
  logic       locked_q;
  logic       lock_sel_q;
  logic       prio_q;

  logic [1:0] req_vld;
  logic       full;
  logic       empty;
  logic       sel;
  logic       push;
  logic       pop;
  logic       head_tag;

  // Pointers wrap modulo FIFO_DEPTH; with a single entry they stay at 0.
  function automatic logic ptr_next(input logic p);
    return (FIFO_DEPTH == 1) ? 1'b0 : ~p;
  endfunction

  assign req_vld = {req1_vld, req0_vld};
  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == 2'd0);

  // A stalled selection stays put until the EX input transfer completes.
  always_comb begin
    sel = prio_q;
    if (locked_q && req_vld[lock_sel_q]) sel = lock_sel_q;
    else if (req_vld[prio_q])            sel = prio_q;
    else                                 sel = ~prio_q;
  end

  assign ex_in_vld = ~rst & ~full & (|req_vld);
  assign ex_decode = sel ? req1_decode : req0_decode;
  assign req0_rdy  = ex_in_vld & ~sel & ex_in_rdy;
  assign req1_rdy  = ex_in_vld & sel & ex_in_rdy;
  assign push      = ex_in_vld & ex_in_rdy;

  assign head_tag    = tag_q[rd_ptr_q];
  assign rsp_execute = ex_execute;
  assign rsp0_vld    = ~rst & ~empty & ~head_tag & ex_out_vld;
  assign rsp1_vld    = ~rst & ~empty & head_tag & ex_out_vld;
  assign ex_out_rdy  = ~rst & ~empty & (head_tag ? rsp1_rdy : rsp0_rdy);
  assign pop         = ex_out_vld & ex_out_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      tag_q      <= 2'b00;
      locked_q   <= 1'b0;
      lock_sel_q <= 1'b0;
    end else begin
      if (push) begin
        tag_q[wr_ptr_q] <= sel;
        wr_ptr_q        <= ptr_next(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_next(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
      locked_q   <= ex_in_vld & ~ex_in_rdy;
      lock_sel_q <= sel;
    end
  end

`ifdef KRONOS_EX_ARB_RR_EN
  // The requester just served yields priority to the other one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       prio_q <= 1'b0;
    else if (push) prio_q <= ~sel;
  end
`else
  assign prio_q = 1'b0;
`endif

endmodule
